alu_arbiter: RTL and testbench

//  Shares the single combinational ALU between N_REQ requesters (e.g. execute stage, branch unit).

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_rr.sv | 68 ++++++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Covers ALU opcodes, arbiter FSM states and default datapath widths.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ALUC_W_DEF = 5;

  // ALU opcodes; the arbiter forwards aluc untouched, these are for requesters and benches
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLT = 5'b00101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Request arbiter: valid vector -> one-hot grant and encoded id.
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] valid_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] gnt_c_o,
  output logic [ID_W-1:0]  id_c_o,
  output logic             any_c_o
);

  logic [ID_W-1:0] idx_w;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk_i, rst_ni, advance_i};

  always_comb begin
    gnt_c_o = '0;
    id_c_o  = '0;
    any_c_o = 1'b0;
    idx_w   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_w = ID_W'(k);
      if (!any_c_o && valid_i[idx_w]) begin
        any_c_o        = 1'b1;
        gnt_c_o[idx_w] = 1'b1;
        id_c_o         = idx_w;
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Scan starts at the pointer and wraps modulo N_REQ (non-power-of-2 safe)
  always_comb begin
    gnt_c_o = '0;
    id_c_o  = '0;
    any_c_o = 1'b0;
    idx_w   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_w = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!any_c_o && valid_i[idx_w]) begin
        any_c_o        = 1'b1;
        gnt_c_o[idx_w] = 1'b1;
        id_c_o         = idx_w;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_c_o) begin
      ptr_d = (id_c_o == ID_W'(N_REQ - 1)) ? '0 : id_c_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: IDLE -> EXEC -> RESP.
// Config macro: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin, inside rr_arbiter).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ALUC_W = ALUC_W_DEF,
  parameter int unsigned N_REQ  = 2,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_a_i,
  input  logic [N_REQ*DATA_W-1:0] req_b_i,
  input  logic [N_REQ*ALUC_W-1:0] req_aluc_i,
  output logic [DATA_W-1:0]       alu_a_o,
  output logic [DATA_W-1:0]       alu_b_o,
  output logic [ALUC_W-1:0]       alu_aluc_o,
  input  logic [DATA_W-1:0]       alu_c_i,
  input  logic                    alu_branch_i,
  input  logic [1:0]              alu_branch2_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_c_o,
  output logic                    rsp_branch_o,
  output logic [1:0]              rsp_branch2_o
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ALUC_W-1:0] aluc_q, aluc_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              br_q, br_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]        br2_q, br2_d;

  logic [N_REQ-1:0]  gnt_c;
  logic [ID_W-1:0]   win_id_c;
  logic              win_c, req_hs_c;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (req_valid_i),
    .advance_i (req_hs_c),
    .gnt_c_o   (gnt_c),
    .id_c_o    (win_id_c),
    .any_c_o   (win_c)
  );

  assign req_ready_o = (state_q == S_IDLE) ? gnt_c : '0;
  assign req_hs_c    = (state_q == S_IDLE) && win_c;

  // Next-state and holding-register update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    aluc_d      = aluc_q;
    id_d        = id_q;
    c_d         = c_q;
    br_d        = br_q;
    br2_d       = br2_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_hs_c) begin
          for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_id_c == ID_W'(k)) begin
              a_d    = req_a_i[k*DATA_W +: DATA_W];
              b_d    = req_b_i[k*DATA_W +: DATA_W];
              aluc_d = req_aluc_i[k*ALUC_W +: ALUC_W];
            end
          end
          id_d    = win_id_c;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        c_d         = alu_c_i;
        br_d        = alu_branch_i;
        br2_d       = alu_branch2_i;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      aluc_q      <= '0;
      id_q        <= '0;
      c_q         <= '0;
      br_q        <= 1'b0;
      br2_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluc_q      <= aluc_d;
      id_q        <= id_d;
      c_q         <= c_d;
      br_q        <= br_d;
      br2_q       <= br2_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_aluc_o    = aluc_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = id_q;
  assign rsp_c_o       = c_q;
  assign rsp_branch_o  = br_q;
  assign rsp_branch2_o = br2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 3-requester instance share one behavioural ALU model.
// Expected grant orders follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    logic [31:0] c;
    case (op)
      ALU_ADD: c = a + b;
      ALU_SUB: c = a - b;
      ALU_AND: c = a & b;
      ALU_OR:  c = a | b;
      ALU_XOR: c = a ^ b;
      ALU_SLT: c = {31'b0, $signed(a) < $signed(b)};
      default: c = 32'hDEAD_BEEF;
    endcase
    return {c, a == b, $signed(a) < $signed(b), a < b};
  endfunction

  // Instance d0: N_REQ=2
  logic [1:0]  v0, rdy0;
  logic [63:0] a0, b0;
  logic [9:0]  aluc0;
  logic [31:0] alu_a0, alu_b0, c0, rc0;
  logic [4:0]  aluc_o0;
  logic        br0, rv0, rr0, rb0;
  logic [1:0]  br20, rb20;
  logic [0:0]  id0;

  assign {c0, br0, br20} = alu_f(alu_a0, alu_b0, aluc_o0);

  alu_arbiter #(.DATA_W(32), .ALUC_W(5), .N_REQ(2)) d0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v0), .req_ready_o(rdy0),
    .req_a_i(a0), .req_b_i(b0), .req_aluc_i(aluc0),
    .alu_a_o(alu_a0), .alu_b_o(alu_b0), .alu_aluc_o(aluc_o0),
    .alu_c_i(c0), .alu_branch_i(br0), .alu_branch2_i(br20),
    .rsp_valid_o(rv0), .rsp_ready_i(rr0), .rsp_id_o(id0),
    .rsp_c_o(rc0), .rsp_branch_o(rb0), .rsp_branch2_o(rb20)
  );

  // Instance d3: N_REQ=3
  logic [2:0]  v3, rdy3;
  logic [95:0] a3, b3;
  logic [14:0] aluc3;
  logic [31:0] alu_a3, alu_b3, c3, rc3;
  logic [4:0]  aluc_o3;
  logic        br3, rv3, rr3, rb3;
  logic [1:0]  br23, rb23, id3;

  assign {c3, br3, br23} = alu_f(alu_a3, alu_b3, aluc_o3);

  alu_arbiter #(.DATA_W(32), .ALUC_W(5), .N_REQ(3)) d3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v3), .req_ready_o(rdy3),
    .req_a_i(a3), .req_b_i(b3), .req_aluc_i(aluc3),
    .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_aluc_o(aluc_o3),
    .alu_c_i(c3), .alu_branch_i(br3), .alu_branch2_i(br23),
    .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_id_o(id3),
    .rsp_c_o(rc3), .rsp_branch_o(rb3), .rsp_branch2_o(rb23)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int e;
    logic [31:0] ec;
    rst_n = 1'b0;
    v0 = '0; a0 = '0; b0 = '0; aluc0 = '0; rr0 = 1'b1;
    v3 = '0; a3 = '0; b3 = '0; aluc3 = '0; rr3 = 1'b1;
    step(); step();
    chk("reset_ready", 64'(rdy0), 64'd0);
    chk("reset_rsp_valid", 64'(rv0), 64'd0);
    chk("reset_rsp_c", 64'(rc0), 64'd0);
    chk("reset_alu_a", 64'(alu_a0), 64'd0);
    chk("reset_id", 64'(id0), 64'd0);
    rst_n = 1'b1;
    step();

    // Single op: 1 + 3
    a0[31:0] = 32'd1; b0[31:0] = 32'd3; aluc0[4:0] = ALU_ADD; v0 = 2'b01;
    #1;
    chk("t1_ready", 64'(rdy0), 64'b01);
    step();
    v0 = 2'b00;
    chk("t1_exec_ready", 64'(rdy0), 64'd0);
    chk("t1_exec_valid", 64'(rv0), 64'd0);
    chk("t1_alu_a", 64'(alu_a0), 64'd1);
    step();
    chk("t1_rsp_valid", 64'(rv0), 64'd1);
    chk("t1_rsp_c", 64'(rc0), 64'd4);
    chk("t1_rsp_id", 64'(id0), 64'd0);
    chk("t1_rsp_br", 64'(rb0), 64'd0);
    chk("t1_rsp_br2", 64'(rb20), 64'b11);
    step();
    chk("t1_done_valid", 64'(rv0), 64'd0);

    // Back-to-back contention from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a0 = {32'd7, 32'd10}; b0 = {32'd5, 32'd2}; aluc0 = {ALU_XOR, ALU_SUB};
    v0 = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 2;
`endif
      ec = (e == 0) ? 32'd8 : 32'd2;
      chk($sformatf("t2_grant%0d", k), 64'(rdy0), 64'(2'b01 << e));
      step();
      chk($sformatf("t2_exec_ready%0d", k), 64'(rdy0), 64'd0);
      step();
      chk($sformatf("t2_rsp_valid%0d", k), 64'(rv0), 64'd1);
      chk($sformatf("t2_rsp_id%0d", k), 64'(id0), 64'(e));
      chk($sformatf("t2_rsp_c%0d", k), 64'(rc0), 64'(ec));
      step();
    end

    // Response back-pressure
    rr0 = 1'b0;
    #1;
    chk("t3_grant", 64'(rdy0), 64'b01);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_hold_valid%0d", k), 64'(rv0), 64'd1);
      chk($sformatf("t3_hold_c%0d", k), 64'(rc0), 64'd8);
      chk($sformatf("t3_hold_id%0d", k), 64'(id0), 64'd0);
      chk($sformatf("t3_hold_ready%0d", k), 64'(rdy0), 64'd0);
      step();
    end
    rr0 = 1'b1;
    #1;
    chk("t3_release_ready", 64'(rdy0), 64'd0);
    step();
    chk("t3_idle_valid", 64'(rv0), 64'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t3_next_grant", 64'(rdy0), 64'b01);
`else
    chk("t3_next_grant", 64'(rdy0), 64'b10);
`endif
    v0 = 2'b00;
    #1;

    // Reset during EXEC drops the op
    a0[31:0] = 32'd1; b0[31:0] = 32'd3; aluc0[4:0] = ALU_ADD; v0 = 2'b01;
    step();
    v0 = 2'b00;
    chk("t4_exec_alu_a", 64'(alu_a0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_alu_a", 64'(alu_a0), 64'd0);
    chk("t4_rst_alu_aluc", 64'(aluc_o0), 64'd0);
    chk("t4_rst_valid", 64'(rv0), 64'd0);
    chk("t4_rst_ready", 64'(rdy0), 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4_no_rsp%0d", k), 64'(rv0), 64'd0);
    end

    // Three requesters: wrap-around and pass-through of an undefined opcode
    a3 = {32'hFFFF_FFFF, 32'd0, 32'd5};
    b3 = {32'd1, 32'd0, 32'd5};
    aluc3 = {5'b11111, ALU_ADD, ALU_AND};
    v3 = 3'b100;
    #1;
    chk("t5_grant2", 64'(rdy3), 64'b100);
    step();
    v3 = 3'b000;
    step();
    chk("t5_rsp_id2", 64'(id3), 64'd2);
    chk("t5_rsp_c2", 64'(rc3), 64'hDEAD_BEEF);
    chk("t5_rsp_br2", 64'(rb3), 64'd0);
    chk("t5_rsp_br2_2", 64'(rb23), 64'b10);
    step();
    v3 = 3'b101;
    #1;
    chk("t5_grant_wrap", 64'(rdy3), 64'b001);
    step(); step();
    chk("t5_rsp_id0", 64'(id3), 64'd0);
    chk("t5_rsp_c0", 64'(rc3), 64'd5);
    chk("t5_rsp_br0", 64'(rb3), 64'd1);
    chk("t5_rsp_br2_0", 64'(rb23), 64'b00);
    step();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t5_grant_next", 64'(rdy3), 64'b001);
`else
    chk("t5_grant_next", 64'(rdy3), 64'b100);
`endif
    step(); step();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t5_rsp_id_next", 64'(id3), 64'd0);
`else
    chk("t5_rsp_id_next", 64'(id3), 64'd2);
`endif
    v3 = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
